hex_digit_entry: RTL
====================

// Module: hex_digit_entry
// PURPOSE
//  Upstream stage of the LCD/DES display path. Builds the 64-bit DES plaintext one hex digit at a time.
//  - Digit source: 4 slide switches.
//  - Commit: one debounced press of the active-low load pushbutton.
//  - oVALUE/oCOUNT feed the DES encrypter and the per-digit hex-to-ASCII converters.
//  - oCOUNT>ii enables display digit ii; oCOUNT==16 enables the ciphertext line.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  stable-level cycles required to accept press/release (20 ms @ 50 MHz); min 2
//  DB_W             20       debounce counter width; 2**DB_W >= DEBOUNCE_CYCLES
//  NDIGITS          16       digits per word (fixed; oVALUE = 4*NDIGITS bits)
// PORTS
//  iCLK      in   1   50 MHz system clock
//  iRST_N    in   1   asynchronous active-low reset
//  iNIB      in   4   hex digit from switches, quasi-static, asynchronous
//  iLOAD_N   in   1   load pushbutton, active-low, asynchronous, bouncy
//  iCLR      in   1   synchronous active-high clear of the entered word
//  oVALUE    out  64  entered word; digit 0 at [63:60], digit 15 at [3:0]
//  oCOUNT    out  5   digits entered, 0..16, saturating
//  oFULL     out  1   oCOUNT==16
//  oDONE     out  1   one-cycle pulse on the edge oCOUNT goes 15->16
//  oHELD     out  1   debounced "button pressed" level
// BEHAVIOUR
//  Reset: iRST_N=0 immediately forces the following; mid-debounce or mid-hold work is discarded.
//  - oVALUE=0, oCOUNT=0, oFULL=0, oDONE=0, oHELD=0
//  - FSM=IDLE, debounce counter=0, synchronizer flops=1 (released)
//  Synchronizers:
//  - iLOAD_N passes through 2 flops -> s_load.
//  - iNIB passes through 2 flops -> s_nib.
//  FSM (debounce counter dbc):
//  - IDLE: s_load==0 -> PRESS_DB, dbc<=0.
//  - PRESS_DB: s_load==1 -> IDLE, no capture. Else if dbc==DEBOUNCE_CYCLES-1 -> HELD and capture. Else dbc++.
//  - HELD: s_load==1 -> REL_DB, dbc<=0.
//  - REL_DB: s_load==0 -> HELD, no new capture. Else if dbc==DEBOUNCE_CYCLES-1 -> IDLE. Else dbc++.
//  - oHELD=1 in HELD and REL_DB.
//  Capture (same edge as PRESS_DB->HELD):
//  - If oCOUNT<16: oVALUE[63-4*oCOUNT -: 4] <= s_nib and oCOUNT <= oCOUNT+1. Other digits unchanged.
//  - If oCOUNT==15 at capture: oDONE=1 on the following cycle only.
//  - If oCOUNT==16: press is debounced normally but nothing changes, and oDONE stays 0.
//  Latency: a clean falling edge of iLOAD_N registered at edge 0 shows on oCOUNT/oVALUE after edge DEBOUNCE_CYCLES+3.
//  iCLR=1:
//  - Sets oVALUE=0, oCOUNT=0, oDONE=0.
//  - Takes priority over a capture on the same edge, so that press is lost.
//  - FSM state is unaffected. A button held through iCLR does not capture again until released and re-pressed.
//  Hold: holding indefinitely yields exactly one capture.
//  Bounce: any glitch shorter than DEBOUNCE_CYCLES restarts the debounce count.
//  oFULL is combinational from oCOUNT. All other outputs are registered.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Reset, iNIB=A, iLOAD_N low 12 cycles -> oCOUNT=1 at edge 7, oVALUE=64'hA000000000000000, oHELD=1 from edge 7.
//  2. iLOAD_N low 2, high 1, low 12 -> exactly one capture; oCOUNT=1 at 7 edges after the second fall.
//  3. 16 press/release pairs with digits 1,3,3,4,5,7,7,9,9,B,B,C,D,F,F,1 -> expected results:
//     - oVALUE=64'h133457799BBCDFF1, oCOUNT=16, oFULL=1
//     - oDONE high exactly one cycle
//     - a 17th press changes nothing
//  4. iCLR pulsed while HELD with oCOUNT=5 -> oVALUE=0, oCOUNT=0, no capture on release; next press with iNIB=7 gives oVALUE=64'h7000...0.
//  5. iRST_N low for 1 cycle while in PRESS_DB at dbc=2 -> all outputs 0 asynchronously; button kept low afterwards captures only after a full new debounce (7 edges).
//  6. iLOAD_N held low 200 cycles, iNIB toggled during hold -> one capture with the nibble sampled at acceptance; oCOUNT=1.

Source files
------------

// File: rtl/hex_digit_entry.sv
// Hex digit entry: builds a 64-bit word one switch nibble at a time, committing a digit
// on each debounced press of the active-low load button.
module hex_digit_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20,
  parameter int NDIGITS         = 16
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic [3:0]             iNIB,
  input  logic                   iLOAD_N,
  input  logic                   iCLR,
  output logic [4*NDIGITS-1:0]   oVALUE,
  output logic [4:0]             oCOUNT,
  output logic                   oFULL,
  output logic                   oDONE,
  output logic                   oHELD
);

  localparam int              CNT_W   = 5;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NDIGITS);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(NDIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  state_t            state, stateNext;
  logic [DB_W-1:0]   dbc, dbcNext;
  logic              loadMeta, sLoad;
  logic [3:0]        nibMeta, sNib;
  logic              capture, heldNext;

  // Two-flop synchronizers; reset to the "released" level so no phantom press follows reset.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      loadMeta <= 1'b1;
      sLoad    <= 1'b1;
      nibMeta  <= '1;
      sNib     <= '1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      loadMeta <= iLOAD_N;
      sLoad    <= loadMeta;
      nibMeta  <= iNIB;
      sNib     <= nibMeta;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      dbc   <= '0;
    end else begin
      state <= stateNext;
      dbc   <= dbcNext;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    stateNext = state;
    dbcNext   = dbc;
    unique case (state)
      IDLE: begin
        if (!sLoad) begin
          stateNext = PRESS_DB;
          dbcNext   = '0;
        end
      end
      PRESS_DB: begin
        if (sLoad)                stateNext = IDLE;
        else if (dbc == DB_LAST)  stateNext = HELD;
        else                      dbcNext   = dbc + 1'b1;
      end
      HELD: begin
        if (sLoad) begin
          stateNext = REL_DB;
          dbcNext   = '0;
        end
      end
      REL_DB: begin
        if (!sLoad)               stateNext = HELD;
        else if (dbc == DB_LAST)  stateNext = IDLE;
        else                      dbcNext   = dbc + 1'b1;
      end
      default: begin
        stateNext = IDLE;
        dbcNext   = '0;
      end
    endcase
  end

  always_comb begin
    capture  = (state == PRESS_DB) && !sLoad && (dbc == DB_LAST);
    heldNext = (stateNext == HELD) || (stateNext == REL_DB);
  end

  // Entered word: clear wins over a simultaneous capture; a full word ignores further presses.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVALUE <= '0;
      oCOUNT <= '0;
      oDONE  <= 1'b0;
      oHELD  <= 1'b0;
    end else begin
      oHELD <= heldNext;
      oDONE <= 1'b0;
      if (iCLR) begin
        oVALUE <= '0;
        oCOUNT <= '0;
      end else if (capture && (oCOUNT != CNT_MAX)) begin
        for (int i = 0; i < NDIGITS; i++) begin
          if (oCOUNT == CNT_W'(i)) oVALUE[4*(NDIGITS-1-i) +: 4] <= sNib;
        end
        oCOUNT <= oCOUNT + 5'd1;
        oDONE  <= (oCOUNT == CNT_PENULT);
      end
    end
  end

  assign oFULL = (oCOUNT == CNT_MAX);

endmodule
